// File: rtl/memory_stage_if.sv
// memory_stage_if
//   Data-cache bus between the MIPS memory stage and the data cache.
//   The memory stage is the master: it raises a read or write request,
//   presents the address and store data, and keeps the request up until
//   the cache answers with dhit.
//
//   Signals:
//     dmemREN    master -> cache   read request
//     dmemWEN    master -> cache   write request (never together with dmemREN)
//     dmemaddr   master -> cache   byte address of the access
//     dmemstore  master -> cache   data to be written
//     dhit       cache  -> master  access complete / read data valid
//     dmemload   cache  -> master  read data
interface memory_stage_if;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        dhit;
  logic [31:0] dmemload;

  // Memory stage side of the bus.
  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  dhit, dmemload
  );

  // Data cache side of the bus.
  modport slave (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore,
    output dhit, dmemload
  );
endinterface

// File: rtl/memory_stage.sv
// memory_stage
//   MEM stage of the five-stage MIPS pipeline, fed by the EX/MEM latch.
//   It issues data-cache requests and waits for dhit, freezes the front
//   of the pipe while a miss is outstanding, resolves branches/jumps into
//   a PC redirect (which doubles as the IF/ID and ID/EX flush), and owns
//   the MEM/WB register that feeds writeback. Once a halt retires the
//   stage parks in HALTED until reset.
//
//   Ports:
//     CLK, RST            clock (rising edge), async active-high reset
//     pc_plus_4           PC+4 of the instruction in MEM (JAL link value)
//     baddr, jaddr        branch target, jump target
//     zero                ALU zero flag
//     portout             ALU result, also the data address
//     rdat2               store data
//     Branch, bne, Jump, JAL          branch/jump control
//     regWEN, MemtoReg, dREN, dWEN, halt, wsel   instruction control
//     dbus                data-cache bus (master side)
//     mem_stall           freeze PC and IF/ID/EX latches
//     pc_redirect         take branch/jump, flush upstream latches
//     pc_target           redirect address
//     wb_regWEN, wb_wsel, wb_wdat, wb_halt   MEM/WB register outputs
//     stall_cnt           saturating count of stall cycles
module memory_stage #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,

  input  logic [31:0]      pc_plus_4,
  input  logic [31:0]      baddr,
  input  logic [31:0]      jaddr,
  input  logic             zero,
  input  logic [31:0]      portout,
  input  logic [31:0]      rdat2,
  input  logic             Branch,
  input  logic             bne,
  input  logic             Jump,
  input  logic             JAL,
  input  logic             regWEN,
  input  logic             MemtoReg,
  input  logic             dREN,
  input  logic             dWEN,
  input  logic             halt,
  input  logic [4:0]       wsel,

  memory_stage_if.master   dbus,

  output logic             mem_stall,
  output logic             pc_redirect,
  output logic [31:0]      pc_target,
  output logic             wb_regWEN,
  output logic [4:0]       wb_wsel,
  output logic [31:0]      wb_wdat,
  output logic             wb_halt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] STALL_MAX = '1;
  localparam logic [CNT_W-1:0] STALL_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t      state;
  logic        halted;
  logic        acc;
  logic        taken;
  logic [4:0]  wsel_next;
  logic [31:0] wdat_next;

  assign halted = (state == HALTED);

  // A data access is live whenever the instruction in MEM wants memory and
  // the core has not halted. Gating with RST makes the request vanish the
  // instant reset is raised, even in the middle of a miss, so the cache
  // never sees a request the pipeline has already forgotten.
  assign acc = (dREN | dWEN) & ~halted & ~RST;

  // A read wins when an instruction (incorrectly) asks for both.
  assign dbus.dmemREN   = acc & dREN;
  assign dbus.dmemWEN   = acc & dWEN & ~dREN;
  assign dbus.dmemaddr  = portout;
  assign dbus.dmemstore = rdat2;

  // The stall is combinational so the upstream latches freeze in the very
  // cycle the cache fails to answer; the EX/MEM latch holding its value is
  // what keeps the request steady until dhit.
  assign mem_stall = acc & ~dbus.dhit;

  // Branch resolution. bne inverts the sense of the zero test; a jump
  // always redirects. Everything is silenced once halted so a stale
  // branch in the EX/MEM latch cannot move the PC.
  assign taken       = Jump | (Branch & (zero ^ bne));
  assign pc_redirect = ~halted & taken;
  assign pc_target   = halted ? 32'd0 : (Jump ? jaddr : baddr);

  // Writeback selection: JAL links PC+4 into $ra, loads take the cache
  // data, everything else takes the ALU result.
  always_comb begin
    wsel_next = wsel;
    wdat_next = portout;
    if (JAL) begin
      wsel_next = 5'd31;
      wdat_next = pc_plus_4;
    end else if (MemtoReg) begin
      wdat_next = dbus.dmemload;
    end
  end

  // Control FSM together with the MEM/WB register and the stall counter.
  // While stalled the register receives a bubble (no write, no halt) but
  // keeps wsel/wdat so nothing downstream sees spurious data changes. A
  // halt is only taken on a cycle that is not stalled, which means a halt
  // riding on a memory access retires on the dhit cycle. HALTED is
  // absorbing: it pins wb_halt high and blocks all further captures.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      wb_regWEN <= 1'b0;
      wb_wsel   <= 5'd0;
      wb_wdat   <= 32'd0;
      wb_halt   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (mem_stall && (stall_cnt != STALL_MAX)) begin
        stall_cnt <= stall_cnt + STALL_ONE;
      end

      case (state)
        IDLE, WAIT: begin
          if (mem_stall) begin
            state     <= WAIT;
            wb_regWEN <= 1'b0;
            wb_halt   <= 1'b0;
          end else begin
            state     <= halt ? HALTED : IDLE;
            wb_regWEN <= regWEN;
            wb_wsel   <= wsel_next;
            wb_wdat   <= wdat_next;
            wb_halt   <= halt;
          end
        end

        HALTED: begin
          wb_regWEN <= 1'b0;
          wb_halt   <= 1'b1;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage
//   Self-checking bench for memory_stage. Each scenario lives in its own
//   test_* task; expected values come from a small behavioural model of
//   the stage (access latency, writeback selection, stall accounting).
module tb_memory_stage;

  localparam int CNT_W = 16;

  logic             CLK;
  logic             RST;
  logic [31:0]      pc_plus_4;
  logic [31:0]      baddr;
  logic [31:0]      jaddr;
  logic             zero;
  logic [31:0]      portout;
  logic [31:0]      rdat2;
  logic             Branch;
  logic             bne;
  logic             Jump;
  logic             JAL;
  logic             regWEN;
  logic             MemtoReg;
  logic             dREN;
  logic             dWEN;
  logic             halt;
  logic [4:0]       wsel;
  logic             mem_stall;
  logic             pc_redirect;
  logic [31:0]      pc_target;
  logic             wb_regWEN;
  logic [4:0]       wb_wsel;
  logic [31:0]      wb_wdat;
  logic             wb_halt;
  logic [CNT_W-1:0] stall_cnt;

  memory_stage_if dbus ();

  int tests_run    = 0;
  int tests_failed = 0;

  memory_stage #(.CNT_W(CNT_W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .pc_plus_4  (pc_plus_4),
    .baddr      (baddr),
    .jaddr      (jaddr),
    .zero       (zero),
    .portout    (portout),
    .rdat2      (rdat2),
    .Branch     (Branch),
    .bne        (bne),
    .Jump       (Jump),
    .JAL        (JAL),
    .regWEN     (regWEN),
    .MemtoReg   (MemtoReg),
    .dREN       (dREN),
    .dWEN       (dWEN),
    .halt       (halt),
    .wsel       (wsel),
    .dbus       (dbus.master),
    .mem_stall  (mem_stall),
    .pc_redirect(pc_redirect),
    .pc_target  (pc_target),
    .wb_regWEN  (wb_regWEN),
    .wb_wsel    (wb_wsel),
    .wb_wdat    (wb_wdat),
    .wb_halt    (wb_halt),
    .stall_cnt  (stall_cnt)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Safety net so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clear_inputs();
    pc_plus_4     = 32'd0;
    baddr         = 32'd0;
    jaddr         = 32'd0;
    zero          = 1'b0;
    portout       = 32'd0;
    rdat2         = 32'd0;
    Branch        = 1'b0;
    bne           = 1'b0;
    Jump          = 1'b0;
    JAL           = 1'b0;
    regWEN        = 1'b0;
    MemtoReg      = 1'b0;
    dREN          = 1'b0;
    dWEN          = 1'b0;
    halt          = 1'b0;
    wsel          = 5'd0;
    dbus.dhit     = 1'b0;
    dbus.dmemload = 32'd0;
  endtask

  // Advance to just after the next active edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_reset();
    clear_inputs();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    tick();
    tests_run++;
    if ({wb_regWEN, wb_wsel, wb_wdat, wb_halt, stall_cnt} !== {1'b0, 5'd0, 32'd0, 1'b0, 16'd0}) begin
      tests_failed++;
      $display("[TB] FAIL reset_regs: got %h expected %h",
               {wb_regWEN, wb_wsel, wb_wdat, wb_halt, stall_cnt}, {1'b0, 5'd0, 32'd0, 1'b0, 16'd0});
    end
    tests_run++;
    if ({dbus.dmemREN, dbus.dmemWEN, dbus.dmemaddr, mem_stall, pc_redirect, pc_target} !== {1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0}) begin
      tests_failed++;
      $display("[TB] FAIL reset_comb: got %h expected 0",
               {dbus.dmemREN, dbus.dmemWEN, dbus.dmemaddr, mem_stall, pc_redirect, pc_target});
    end
    dREN = 1'b1;
    #1;
    tests_run++;
    if ({dbus.dmemREN, mem_stall} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL reset_req_blocked: got %b expected 00", {dbus.dmemREN, mem_stall});
    end
    dREN = 1'b0;
    RST  = 1'b0;
    tick();
  endtask

  task automatic test_load_miss();
    logic exp_stall_b;
    pulse_reset();
    dREN          = 1'b1;
    MemtoReg      = 1'b1;
    regWEN        = 1'b1;
    wsel          = 5'd8;
    portout       = 32'h100;
    dbus.dmemload = 32'hDEADBEEF;
    for (int c = 0; c < 4; c++) begin
      dbus.dhit   = (c == 3);
      exp_stall_b = (c < 3);
      #1;
      tests_run++;
      if ({dbus.dmemREN, dbus.dmemWEN, dbus.dmemaddr} !== {1'b1, 1'b0, 32'h100}) begin
        tests_failed++;
        $display("[TB] FAIL load_req cycle %0d: got %h expected %h",
                 c, {dbus.dmemREN, dbus.dmemWEN, dbus.dmemaddr}, {1'b1, 1'b0, 32'h100});
      end
      tests_run++;
      if (mem_stall !== exp_stall_b) begin
        tests_failed++;
        $display("[TB] FAIL load_stall cycle %0d: got %b expected %b", c, mem_stall, exp_stall_b);
      end
      tick();
      if (c < 3) begin
        tests_run++;
        if (wb_regWEN !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL load_bubble cycle %0d: got %b expected 0", c, wb_regWEN);
        end
      end
    end
    tests_run++;
    if (stall_cnt !== 16'd3) begin
      tests_failed++;
      $display("[TB] FAIL load_stall_cnt: got %0d expected 3", stall_cnt);
    end
    tests_run++;
    if ({wb_regWEN, wb_wsel, wb_wdat, wb_halt} !== {1'b1, 5'd8, 32'hDEADBEEF, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL load_wb: got %h expected %h",
               {wb_regWEN, wb_wsel, wb_wdat, wb_halt}, {1'b1, 5'd8, 32'hDEADBEEF, 1'b0});
    end
    clear_inputs();
  endtask

  task automatic test_store_hit();
    pulse_reset();
    dWEN      = 1'b1;
    rdat2     = 32'h12345678;
    portout   = 32'h200;
    dbus.dhit = 1'b1;
    #1;
    tests_run++;
    if ({dbus.dmemREN, dbus.dmemWEN, dbus.dmemaddr, dbus.dmemstore, mem_stall} !==
        {1'b0, 1'b1, 32'h200, 32'h12345678, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL store_req: got %h expected %h",
               {dbus.dmemREN, dbus.dmemWEN, dbus.dmemaddr, dbus.dmemstore, mem_stall},
               {1'b0, 1'b1, 32'h200, 32'h12345678, 1'b0});
    end
    tick();
    tests_run++;
    if ({stall_cnt, wb_regWEN, wb_wdat} !== {16'd0, 1'b0, 32'h200}) begin
      tests_failed++;
      $display("[TB] FAIL store_after: got %h expected %h",
               {stall_cnt, wb_regWEN, wb_wdat}, {16'd0, 1'b0, 32'h200});
    end
    dREN = 1'b1;
    #1;
    tests_run++;
    if ({dbus.dmemREN, dbus.dmemWEN} !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL read_wins: got %b expected 10", {dbus.dmemREN, dbus.dmemWEN});
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_branches();
    logic        exp_red;
    logic [31:0] exp_tgt;
    pulse_reset();
    for (int i = 0; i < 27; i++) begin
      case (i)
        0: begin Branch = 1'b1; bne = 1'b0; zero = 1'b1; Jump = 1'b0; baddr = 32'h40; jaddr = 32'h0; end
        1: begin Branch = 1'b1; bne = 1'b1; zero = 1'b1; Jump = 1'b0; baddr = 32'h44; jaddr = 32'h0; end
        2: begin Branch = 1'b0; bne = 1'b0; zero = 1'b0; Jump = 1'b1; baddr = 32'h0;  jaddr = 32'h80; end
        default: begin
          Branch = 1'($urandom_range(0, 1));
          bne    = 1'($urandom_range(0, 1));
          zero   = 1'($urandom_range(0, 1));
          Jump   = 1'($urandom_range(0, 1));
          baddr  = $urandom;
          jaddr  = $urandom;
        end
      endcase
      if (Jump)        exp_red = 1'b1;
      else if (Branch) exp_red = bne ? !zero : zero;
      else             exp_red = 1'b0;
      exp_tgt = Jump ? jaddr : baddr;
      #1;
      tests_run++;
      if ({pc_redirect, pc_target} !== {exp_red, exp_tgt}) begin
        tests_failed++;
        $display("[TB] FAIL branch_%0d: got %b/%h expected %b/%h",
                 i, pc_redirect, pc_target, exp_red, exp_tgt);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_jal();
    pulse_reset();
    pc_plus_4 = 32'h24;
    JAL       = 1'b1;
    regWEN    = 1'b1;
    wsel      = 5'd4;
    portout   = 32'hCAFE0000;
    tick();
    tests_run++;
    if ({wb_regWEN, wb_wsel, wb_wdat} !== {1'b1, 5'd31, 32'h24}) begin
      tests_failed++;
      $display("[TB] FAIL jal_wb: got %h expected %h",
               {wb_regWEN, wb_wsel, wb_wdat}, {1'b1, 5'd31, 32'h24});
    end
    clear_inputs();
  endtask

  task automatic test_random_pipeline();
    int          kind;
    int          lat;
    int          exp_stall;
    logic        exp_ren;
    logic        exp_wen;
    logic        exp_stall_b;
    logic [4:0]  prev_wsel;
    logic [31:0] prev_wdat;
    logic [4:0]  exp_wsel;
    logic [31:0] exp_wdat;
    pulse_reset();
    exp_stall = 0;
    prev_wsel = 5'd0;
    prev_wdat = 32'd0;
    for (int n = 0; n < 40; n++) begin
      kind          = int'($urandom_range(0, 3));
      lat           = (kind == 0) ? 0 : int'($urandom_range(0, 3));
      dREN          = (kind == 1) || (kind == 3);
      dWEN          = (kind >= 2);
      regWEN        = 1'($urandom_range(0, 1));
      MemtoReg      = 1'($urandom_range(0, 1));
      JAL           = ($urandom_range(0, 7) == 0);
      wsel          = 5'($urandom);
      portout       = $urandom;
      rdat2         = $urandom;
      pc_plus_4     = $urandom;
      dbus.dmemload = $urandom;
      exp_ren       = dREN;
      exp_wen       = dWEN && !dREN;
      for (int c = 0; c <= lat; c++) begin
        dbus.dhit   = (kind == 0) ? 1'($urandom_range(0, 1)) : (c == lat);
        exp_stall_b = (c < lat);
        #1;
        tests_run++;
        if ({dbus.dmemREN, dbus.dmemWEN, dbus.dmemaddr, dbus.dmemstore, mem_stall} !==
            {exp_ren, exp_wen, portout, rdat2, exp_stall_b}) begin
          tests_failed++;
          $display("[TB] FAIL rand_req %0d.%0d: got %h expected %h", n, c,
                   {dbus.dmemREN, dbus.dmemWEN, dbus.dmemaddr, dbus.dmemstore, mem_stall},
                   {exp_ren, exp_wen, portout, rdat2, exp_stall_b});
        end
        tick();
        if (c < lat) begin
          exp_stall++;
          tests_run++;
          if ({wb_regWEN, wb_wsel, wb_wdat, wb_halt} !== {1'b0, prev_wsel, prev_wdat, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL rand_bubble %0d.%0d: got %h expected %h", n, c,
                     {wb_regWEN, wb_wsel, wb_wdat, wb_halt}, {1'b0, prev_wsel, prev_wdat, 1'b0});
          end
        end
      end
      exp_wsel = JAL ? 5'd31 : wsel;
      exp_wdat = JAL ? pc_plus_4 : (MemtoReg ? dbus.dmemload : portout);
      tests_run++;
      if ({wb_regWEN, wb_wsel, wb_wdat, wb_halt} !== {regWEN, exp_wsel, exp_wdat, 1'b0}) begin
        tests_failed++;
        $display("[TB] FAIL rand_wb %0d: got %h expected %h", n,
                 {wb_regWEN, wb_wsel, wb_wdat, wb_halt}, {regWEN, exp_wsel, exp_wdat, 1'b0});
      end
      tests_run++;
      if (stall_cnt !== 16'(exp_stall)) begin
        tests_failed++;
        $display("[TB] FAIL rand_stall_cnt %0d: got %0d expected %0d", n, stall_cnt, exp_stall);
      end
      prev_wsel = exp_wsel;
      prev_wdat = exp_wdat;
    end
    clear_inputs();
  endtask

  task automatic test_halt();
    logic [31:0] load_val;
    logic [31:0] jump_to;
    pulse_reset();
    load_val      = $urandom;
    dREN          = 1'b1;
    MemtoReg      = 1'b1;
    regWEN        = 1'b0;
    wsel          = 5'd9;
    halt          = 1'b1;
    dbus.dmemload = load_val;
    for (int c = 0; c < 2; c++) begin
      dbus.dhit = 1'b0;
      tick();
      tests_run++;
      if (wb_halt !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL halt_early cycle %0d: got %b expected 0", c, wb_halt);
      end
    end
    dbus.dhit = 1'b1;
    tick();
    tests_run++;
    if ({wb_regWEN, wb_wsel, wb_wdat, wb_halt} !== {1'b0, 5'd9, load_val, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL halt_capture: got %h expected %h",
               {wb_regWEN, wb_wsel, wb_wdat, wb_halt}, {1'b0, 5'd9, load_val, 1'b1});
    end
    jump_to   = $urandom;
    halt      = 1'b0;
    dbus.dhit = 1'b0;
    regWEN    = 1'b1;
    wsel      = 5'd3;
    portout   = $urandom;
    Branch    = 1'b1;
    zero      = 1'b1;
    Jump      = 1'b1;
    jaddr     = jump_to;
    for (int c = 0; c < 10; c++) begin
      #1;
      tests_run++;
      if ({dbus.dmemREN, dbus.dmemWEN, mem_stall, pc_redirect, pc_target} !== {1'b0, 1'b0, 1'b0, 1'b0, 32'd0}) begin
        tests_failed++;
        $display("[TB] FAIL halted_comb cycle %0d: got %h expected 0", c,
                 {dbus.dmemREN, dbus.dmemWEN, mem_stall, pc_redirect, pc_target});
      end
      tick();
      tests_run++;
      if ({wb_regWEN, wb_wsel, wb_wdat, wb_halt, stall_cnt} !== {1'b0, 5'd9, load_val, 1'b1, 16'd2}) begin
        tests_failed++;
        $display("[TB] FAIL halted_hold cycle %0d: got %h expected %h", c,
                 {wb_regWEN, wb_wsel, wb_wdat, wb_halt, stall_cnt},
                 {1'b0, 5'd9, load_val, 1'b1, 16'd2});
      end
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] load_val;
    pulse_reset();
    dREN      = 1'b1;
    regWEN    = 1'b1;
    wsel      = 5'd7;
    portout   = 32'hA5A5;
    dbus.dhit = 1'b1;
    tick();
    portout   = 32'h300;
    dbus.dhit = 1'b0;
    #1;
    tests_run++;
    if (mem_stall !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL rstwait_first_stall: got %b expected 1", mem_stall);
    end
    tick();
    #2;
    RST = 1'b1;
    #1;
    tests_run++;
    if ({dbus.dmemREN, mem_stall} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL rstwait_req_drop: got %b expected 00", {dbus.dmemREN, mem_stall});
    end
    tests_run++;
    if ({wb_regWEN, wb_wsel, wb_wdat, wb_halt, stall_cnt} !== {1'b0, 5'd0, 32'd0, 1'b0, 16'd0}) begin
      tests_failed++;
      $display("[TB] FAIL rstwait_regs: got %h expected 0",
               {wb_regWEN, wb_wsel, wb_wdat, wb_halt, stall_cnt});
    end
    clear_inputs();
    tick();
    RST = 1'b0;
    tick();
    load_val      = $urandom;
    dREN          = 1'b1;
    MemtoReg      = 1'b1;
    regWEN        = 1'b1;
    wsel          = 5'd12;
    dbus.dmemload = load_val;
    #1;
    tests_run++;
    if ({dbus.dmemREN, mem_stall} !== 2'b11) begin
      tests_failed++;
      $display("[TB] FAIL rstwait_idle_req: got %b expected 11", {dbus.dmemREN, mem_stall});
    end
    tick();
    dbus.dhit = 1'b1;
    #1;
    tick();
    tests_run++;
    if ({wb_regWEN, wb_wsel, wb_wdat, wb_halt, stall_cnt} !== {1'b1, 5'd12, load_val, 1'b0, 16'd1}) begin
      tests_failed++;
      $display("[TB] FAIL rstwait_recover: got %h expected %h",
               {wb_regWEN, wb_wsel, wb_wdat, wb_halt, stall_cnt},
               {1'b1, 5'd12, load_val, 1'b0, 16'd1});
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    RST = 1'b1;
    test_reset();
    test_load_miss();
    test_store_hit();
    test_branches();
    test_jal();
    test_random_pipeline();
    test_halt();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
